trace_capture: RTL and testbench

On-chip trace buffer that sits inside `core` and collects stimulus/response samples from the datapath probes (XOR, ALU, register, three-stage pipeline). It is the data-producing end of the sample stream the testbench otherwise prints directly. After reset release it waits a fixed hold-off, then writes each valid sample into a circular FIFO. A reader drains the FIFO over a valid/ready port. Overflow is detected, counted and flagged, never silently lost.

---
 rtl/trace_pkg.sv | 8 +
 rtl/trace_fifo.sv | 39 +++
 rtl/trace_capture.sv | 64 ++++++
 tb/tb_trace_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared state type and default parameters for trace_capture
package trace_pkg;
  typedef enum logic {HOLDOFF, CAPTURE} trace_state_e;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_HOLDOFF = 3;
  localparam int DROP_W = 16;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular show-ahead FIFO; clk/rst, i_push/i_pop/i_data in, o_data/o_count/o_full/o_empty out
module trace_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DATA_W-1:0]          i_data,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_count = r_count;
  assign o_empty = r_count == '0;
  assign o_full = r_count == CW'(DEPTH);
  assign o_data = o_empty ? '0 : r_mem[r_rd];
endmodule

// File: rtl/trace_capture.sv
// trace_capture: hold-off then capture samples into a FIFO drained over valid/ready, with sticky overflow and saturating drop count
module trace_capture import trace_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic [DATA_W-1:0]          sample_data,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic                       armed,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);
  localparam int HW = $clog2(HOLDOFF + 2);
  trace_state_e r_state, w_next;
  logic [HW-1:0] r_hcnt;
  logic r_overflow;
  logic [DROP_W-1:0] r_drops;
  logic w_hold, w_done, w_push, w_pop, w_drop, w_empty;
  assign w_done = (HOLDOFF <= 1) || (r_hcnt == HW'(HOLDOFF - 1));
  always_comb begin
    w_hold = r_state == trace_pkg::HOLDOFF;
    w_next = (w_hold && w_done) ? CAPTURE : r_state;
    w_pop = out_valid && out_ready;
    w_push = !w_hold && sample_valid && (!full || w_pop);
    w_drop = !w_hold && sample_valid && full && !w_pop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= trace_pkg::HOLDOFF;
      r_hcnt <= '0;
      r_overflow <= 1'b0;
      r_drops <= '0;
    end else begin
      r_state <= w_next;
      if (w_hold && !w_done) r_hcnt <= r_hcnt + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drops <= r_drops + DROP_W'(r_drops != '1);
      end
    end
  end
  trace_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(sample_data),
    .o_data(out_data),
    .o_count(count),
    .o_full(full),
    .o_empty(w_empty)
  );
  assign out_valid = !w_empty;
  assign armed = r_state == CAPTURE;
  assign overflow = r_overflow;
  assign drop_count = r_drops;
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: table, directed and random checks of trace_capture against a queue-based reference model
module tb_trace_capture;
  localparam int HO = 3;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic reset = 1;
  logic sample_valid = 0;
  logic [31:0] sample_data = 0;
  logic out_valid;
  logic [31:0] out_data;
  logic out_ready = 0;
  logic armed;
  logic [4:0] count;
  logic full;
  logic overflow;
  logic [15:0] drop_count;
  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  int edges = 0;
  bit m_ovf = 0;
  bit written = 0;
  logic [15:0] m_drops = 0;
  bit quiet = 0;
  typedef struct {
    logic v;
    logic [31:0] d;
    logic r;
    logic e_arm;
    logic e_val;
    logic [31:0] e_data;
    int e_cnt;
  } vec_t;
  vec_t tbl[8];
  trace_capture #(.DATA_W(32), .DEPTH(DEPTH), .HOLDOFF(HO)) dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .armed(armed),
    .count(count),
    .full(full),
    .overflow(overflow),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("out_data", out_data, q[0]);
    else if (!written) chk("out_data_unwritten", out_data, 0);
    chk("armed", 32'(armed), 32'(edges >= HO));
    chk("count", 32'(count), q.size());
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
  endtask
  task automatic cycle(input logic v, input logic [31:0] d, input logic r);
    bit arm;
    sample_valid = v;
    sample_data = d;
    out_ready = r;
    reset = 0;
    @(posedge clk);
    arm = edges >= HO;
    if (q.size() > 0 && r) void'(q.pop_front());
    if (arm && v) begin
      if (q.size() < DEPTH) begin
        q.push_back(d);
        written = 1;
      end else begin
        m_ovf = 1;
        if (m_drops != 16'hFFFF) m_drops++;
      end
    end
    edges++;
    #1;
    if (!quiet) check_all();
  endtask
  task automatic do_reset();
    reset = 1;
    sample_valid = 1;
    sample_data = $urandom;
    out_ready = 1;
    @(posedge clk);
    q.delete();
    edges = 0;
    m_ovf = 0;
    m_drops = 0;
    written = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    reset = 0;
  endtask
  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 2, 0, 1, 0, 0, 0};
    tbl[3] = '{1, 3, 0, 1, 1, 3, 1};
    tbl[4] = '{1, 4, 0, 1, 1, 3, 2};
    tbl[5] = '{1, 5, 0, 1, 1, 3, 3};
    tbl[6] = '{1, 6, 1, 1, 1, 4, 3};
    tbl[7] = '{0, 0, 1, 1, 1, 5, 2};
    do_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_armed", i), 32'(armed), 32'(tbl[i].e_arm));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_val));
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_count", i), 32'(count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_drops", i), 32'(drop_count), 0);
    end
    do_reset();
    repeat (HO) cycle(0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, 32'hA0 + i, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_overflow", 32'(overflow), 0);
    cycle(1, 32'hEE, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drops", 32'(drop_count), 1);
    chk("ovf_head", out_data, 32'hA0);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_head", out_data, 32'hA0 + i);
      cycle(1, 32'hB0 + i, 1);
      chk("wrap_count", 32'(count), 16);
      chk("wrap_drops", 32'(drop_count), 1);
    end
    for (int i = 0; i < 15; i++) begin
      chk("drain_order", out_data, (i < 8) ? 32'hA8 + i : 32'hB0 + i - 8);
      cycle(0, 0, 1);
    end
    chk("one_left", 32'(count), 1);
    cycle(1, 32'h55, 1);
    chk("pp1_count", 32'(count), 1);
    chk("pp1_data", out_data, 32'h55);
    cycle(0, 0, 1);
    chk("empty_valid", 32'(out_valid), 0);
    for (int i = 0; i < 17; i++) cycle(1, 32'hC0 + i, 0);
    repeat (7) cycle(0, 0, 1);
    chk("pre_rst_count", 32'(count), 9);
    chk("pre_rst_ovf", 32'(overflow), 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h77, 0);
      chk("rehold_armed", 32'(armed), 32'(i == 2));
      chk("rehold_count", 32'(count), 0);
    end
    cycle(1, 32'h78, 0);
    chk("rehold_first_count", 32'(count), 1);
    chk("rehold_first_data", out_data, 32'h78);
    for (int i = 0; i < 15; i++) cycle(1, 32'hD0 + i, 0);
    chk("sat_full", 32'(full), 1);
    quiet = 1;
    repeat (70000) cycle(1, $urandom, 0);
    quiet = 0;
    chk("sat_drops", 32'(drop_count), 32'hFFFF);
    chk("sat_ovf", 32'(overflow), 1);
    chk("sat_head", out_data, 32'h78);
    cycle(1, 32'h1, 0);
    chk("sat_hold", 32'(drop_count), 32'hFFFF);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else if (i % 600 < 300) cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
      else cycle($urandom_range(0, 1) == 0, $urandom, $urandom_range(0, 2) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
